rv_sdram_bridge: RTL and testbench

//  Upstream feeder for the SDRAM controller's RISC-V port (bank 2, 2MB).
//  - Accepts 32-bit RISC-V softcore memory requests (valid/ready).
//  - Splits each request into one or two 16-bit toggle-handshake transactions on rv_req/rv_req_ack.
//  - Reassembles read data into a 32-bit word and returns it to the core.

---
 rtl/rv_sdram_bridge.sv | 195 +++++++++++++++++++
 tb/tb_rv_sdram_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_sdram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : rv_sdram_bridge
//  Description : Splits 32-bit RISC-V core requests into 16-bit toggle-handshake
//                SDRAM transactions and reassembles read data.
//                Optional one-entry read buffer: define RVBRIDGE_RDBUF_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_sdram_bridge #(
    parameter int ADDR_W = 21
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdram_busy,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [3:0]        mem_wstrb,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic [ADDR_W-2:0] rv_addr,
    output logic [15:0]       rv_din,
    output logic [1:0]        rv_ds,
    output logic              rv_we,
    output logic              rv_req,
    input  logic              rv_req_ack,
    input  logic [15:0]       rv_dout
);

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_IDLE  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CAP   = 3'd4,
        S_RESP  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [ADDR_W-3:0] r_waddr;
    logic [3:0]        r_wstrb;
    logic [31:0]       r_wdata;
    logic              r_half;
    logic              r_ready;
    logic [31:0]       r_rdata;
    logic [ADDR_W-2:0] r_rv_addr;
    logic [15:0]       r_rv_din;
    logic [1:0]        r_rv_ds;
    logic              r_rv_we;
    logic              r_rv_req;

    logic              w_pending;
    logic              w_is_rd;
    logic              w_more;
    logic              w_accept;
    logic              w_first_hi;
    logic              w_rd_hit;
    logic              w_unused_addr;

    assign w_pending     = (r_rv_req != rv_req_ack);
    assign w_is_rd       = (r_wstrb == 4'b0000);
    // A high half is still owed only after the low half has been done.
    assign w_more        = !r_half && (w_is_rd || (r_wstrb[3:2] != 2'b00));
    assign w_accept      = mem_valid && !sdram_busy;
    assign w_first_hi    = (mem_wstrb != 4'b0000) && (mem_wstrb[1:0] == 2'b00);
    assign w_unused_addr = ^mem_addr[1:0];

`ifdef RVBRIDGE_RDBUF_EN
    logic              r_buf_vld;
    logic [ADDR_W-3:0] r_buf_addr;
    logic [31:0]       r_buf_data;
    logic              w_buf_match;

    assign w_buf_match = r_buf_vld && (r_buf_addr == mem_addr[ADDR_W-1:2]);
    assign w_rd_hit    = w_buf_match && (mem_wstrb == 4'b0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_buf_vld  <= 1'b0;
            r_buf_addr <= '0;
            r_buf_data <= '0;
        end else if ((r_state == S_CAP) && r_half) begin
            r_buf_vld  <= 1'b1;
            r_buf_addr <= r_waddr;
            r_buf_data <= {rv_dout, r_rdata[15:0]};
        end else if ((r_state == S_IDLE) && w_accept && w_buf_match && (mem_wstrb != 4'b0000)) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) begin
                    r_buf_data[8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end
`else
    assign w_rd_hit = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_SYNC:  if (!w_pending && !sdram_busy) w_state_nxt = S_IDLE;
            S_IDLE:  if (w_accept) w_state_nxt = w_rd_hit ? S_RESP : S_ISSUE;
            S_ISSUE: if (!sdram_busy) w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (!w_pending) begin
                    if (w_is_rd)     w_state_nxt = S_CAP;
                    else if (w_more) w_state_nxt = S_ISSUE;
                    else             w_state_nxt = S_RESP;
                end
            end
            S_CAP:   w_state_nxt = w_more ? S_ISSUE : S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_waddr   <= '0;
            r_wstrb   <= 4'b0000;
            r_wdata   <= 32'h0;
            r_half    <= 1'b0;
            r_ready   <= 1'b0;
            r_rdata   <= 32'h0;
            r_rv_addr <= '0;
            r_rv_din  <= 16'h0;
            r_rv_ds   <= 2'b00;
            r_rv_we   <= 1'b0;
            r_rv_req  <= 1'b0;
        end else begin
            r_ready <= (w_state_nxt == S_RESP);
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_waddr <= mem_addr[ADDR_W-1:2];
                        r_wstrb <= mem_wstrb;
                        r_wdata <= mem_wdata;
                        r_half  <= w_first_hi;
`ifdef RVBRIDGE_RDBUF_EN
                        if (w_rd_hit) begin
                            r_rdata <= r_buf_data;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    // Address/data/strobes change only together with the toggle.
                    if (!sdram_busy) begin
                        r_rv_addr <= {r_waddr, r_half};
                        r_rv_din  <= r_half ? r_wdata[31:16] : r_wdata[15:0];
                        r_rv_ds   <= w_is_rd ? 2'b11 : (r_half ? r_wstrb[3:2] : r_wstrb[1:0]);
                        r_rv_we   <= !w_is_rd;
                        r_rv_req  <= ~r_rv_req;
                    end
                end
                S_WAIT: begin
                    if (!w_pending && !w_is_rd && w_more) begin
                        r_half <= 1'b1;
                    end
                end
                S_CAP: begin
                    if (r_half) begin
                        r_rdata[31:16] <= rv_dout;
                    end else begin
                        r_rdata[15:0] <= rv_dout;
                    end
                    if (w_more) begin
                        r_half <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_ready = r_ready;
    assign mem_rdata = r_rdata;
    assign rv_addr   = r_rv_addr;
    assign rv_din    = r_rv_din;
    assign rv_ds     = r_rv_ds;
    assign rv_we     = r_rv_we;
    assign rv_req    = r_rv_req;

endmodule
`default_nettype wire

// File: tb/tb_rv_sdram_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rv_sdram_bridge
//  Description : Directed self-checking bench for rv_sdram_bridge with a small
//                toggle-handshake SDRAM model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_sdram_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sdram_busy = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [20:0] mem_addr = '0;
    logic [3:0]  mem_wstrb = 4'b0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic [19:0] rv_addr;
    logic [15:0] rv_din;
    logic [1:0]  rv_ds;
    logic        rv_we;
    logic        rv_req;
    logic        rv_req_ack;
    logic [15:0] rv_dout;

    int checks = 0;
    int failures = 0;

    rv_sdram_bridge #(.ADDR_W(21)) dut (
        .clk        (clk),
        .reset      (reset),
        .sdram_busy (sdram_busy),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .rv_addr    (rv_addr),
        .rv_din     (rv_din),
        .rv_ds      (rv_ds),
        .rv_we      (rv_we),
        .rv_req     (rv_req),
        .rv_req_ack (rv_req_ack),
        .rv_dout    (rv_dout)
    );

    always #5 clk = ~clk;

    // SDRAM controller model: ack after a short latency, read data one clock later.
    logic        model_en = 1'b0;
    logic        ovr_ack = 1'b0;
    logic        m_ack = 1'b0;
    logic        rd_pend = 1'b0;
    logic [15:0] rd_val = 16'h0;
    logic [15:0] m_dout = 16'hF00D;
    int          lat_cnt = 0;
    logic [15:0] mem [0:1023];
    int          n_tx = 0;
    logic [19:0] tx_addr [0:63];
    logic [15:0] tx_din  [0:63];
    logic [1:0]  tx_ds   [0:63];
    logic        tx_we   [0:63];

    assign rv_req_ack = model_en ? m_ack : ovr_ack;
    assign rv_dout    = m_dout;

    always @(posedge clk) begin
        if (model_en && !reset && (rv_req !== m_ack)) begin
            if (lat_cnt == 2) begin
                lat_cnt <= 0;
                m_ack   <= rv_req;
                if (n_tx < 64) begin
                    tx_addr[n_tx] = rv_addr;
                    tx_din[n_tx]  = rv_din;
                    tx_ds[n_tx]   = rv_ds;
                    tx_we[n_tx]   = rv_we;
                end
                n_tx = n_tx + 1;
                if (rv_we) begin
                    if (rv_ds[0]) mem[rv_addr[9:0]][7:0]  = rv_din[7:0];
                    if (rv_ds[1]) mem[rv_addr[9:0]][15:8] = rv_din[15:8];
                end else begin
                    rd_pend <= 1'b1;
                    rd_val  <= mem[rv_addr[9:0]];
                end
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end else begin
            lat_cnt <= 0;
        end
        if (rd_pend) begin
            m_dout  <= rd_val;
            rd_pend <= 1'b0;
        end else begin
            m_dout <= 16'hF00D;
        end
    end

    int   tog_cnt = 0;
    int   rdy_cnt = 0;
    logic last_req = 1'b0;

    always @(negedge clk) begin
        if (rv_req !== last_req) tog_cnt = tog_cnt + 1;
        last_req = rv_req;
    end

    always @(posedge clk) begin
        if (mem_ready === 1'b1) rdy_cnt = rdy_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_req(input logic [20:0] a, input logic [3:0] s, input logic [31:0] d);
        mem_addr  = a;
        mem_wstrb = s;
        mem_wdata = d;
        mem_valid = 1'b1;
    endtask

    task automatic wait_ready(output logic [31:0] rd, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (mem_ready !== 1'b1 && lat < 300);
        check("ready_seen", mem_ready, 1'b1);
        rd        = mem_rdata;
        mem_valid = 1'b0;
        mem_wstrb = 4'b0;
        @(negedge clk);
        check("ready_one_cycle", mem_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          base;
        int          t0;
        int          r0;

        for (int i = 0; i < 1024; i++) mem[i] = 16'h0;
        mem[10'h082] = 16'h1234;
        mem[10'h083] = 16'hABCD;
        mem[10'h020] = 16'h5566;
        mem[10'h021] = 16'h7788;

        // Reset with the ack left high, as if reset hit mid-transaction.
        ovr_ack = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mem_ready", mem_ready, 1'b0);
        check("rst_mem_rdata", mem_rdata, 32'h0);
        check("rst_rv_req", rv_req, 1'b0);
        check("rst_rv_out", {rv_we, rv_ds, rv_din, rv_addr}, 39'h0);
        reset = 1'b0;

        start_req(21'h000104, 4'b0000, 32'h0);
        repeat (8) @(negedge clk);
        check("sync_no_toggle", tog_cnt, 0);
        check("sync_no_ready", rdy_cnt, 0);
        ovr_ack = 1'b0;
        @(negedge clk);
        model_en = 1'b1;
        base = n_tx;
        wait_ready(rd, lat);
        check("rd104_data", rd, 32'hABCD1234);
        check("rd104_ntx", n_tx - base, 2);
        check("rd104_addr_lo", tx_addr[base], 20'h00082);
        check("rd104_addr_hi", tx_addr[base+1], 20'h00083);
        check("rd104_ds_we", {tx_we[base], tx_ds[base]}, 3'b011);
        check("rd104_ready_cnt", rdy_cnt, 1);

        base = n_tx;
        start_req(21'h000200, 4'b1100, 32'hDEADBEEF);
        wait_ready(rd, lat);
        check("wr200_ntx", n_tx - base, 1);
        check("wr200_addr", tx_addr[base], 20'h00101);
        check("wr200_din", tx_din[base], 16'hDEAD);
        check("wr200_ds_we", {tx_we[base], tx_ds[base]}, 3'b111);

        base = n_tx;
        start_req(21'h000010, 4'b0110, 32'h11223344);
        wait_ready(rd, lat);
        check("wr10_ntx", n_tx - base, 2);
        check("wr10_lo", {tx_addr[base], tx_ds[base], tx_din[base]}, {20'h00008, 2'b10, 16'h3344});
        check("wr10_hi", {tx_addr[base+1], tx_ds[base+1], tx_din[base+1]}, {20'h00009, 2'b01, 16'h1122});

        sdram_busy = 1'b1;
        t0 = tog_cnt;
        r0 = rdy_cnt;
        start_req(21'h000010, 4'b0000, 32'h0);
        repeat (10) @(negedge clk);
        check("busy_no_toggle", tog_cnt - t0, 0);
        check("busy_no_ready", rdy_cnt - r0, 0);
        sdram_busy = 1'b0;
        wait_ready(rd, lat);
        check("busy_rd10_data", rd, 32'h00223300);

        start_req(21'h000040, 4'b0000, 32'h0);
        wait_ready(rd, lat);
        check("rd40_first", rd, 32'h77885566);
        t0 = tog_cnt;
        start_req(21'h000040, 4'b0000, 32'h0);
        wait_ready(rd, lat);
        check("rd40_second", rd, 32'h77885566);
`ifdef RVBRIDGE_RDBUF_EN
        check("rd40_hit_latency", lat, 1);
        check("rd40_hit_no_toggle", tog_cnt - t0, 0);
`else
        check("rd40_sdram_toggles", tog_cnt - t0, 2);
`endif
        start_req(21'h000040, 4'b0001, 32'h00000077);
        wait_ready(rd, lat);
        start_req(21'h000040, 4'b0000, 32'h0);
        wait_ready(rd, lat);
        check("rd40_after_wr", rd, 32'h77885577);

        // Asynchronous reset while a read is in flight.
        t0 = tog_cnt;
        start_req(21'h000104, 4'b0000, 32'h0);
        lat = 0;
        while (tog_cnt == t0 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("midrst_issued", rv_req, 1'b1);
        reset = 1'b1;
        #1;
        check("midrst_rv_req", rv_req, 1'b0);
        check("midrst_outs", {mem_ready, rv_we, rv_ds, rv_addr}, 24'h0);
        mem_valid = 1'b0;
        r0 = rdy_cnt;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("midrst_no_ready", rdy_cnt - r0, 0);
        start_req(21'h000200, 4'b0000, 32'h0);
        wait_ready(rd, lat);
        check("post_rst_read", rd, 32'hDEAD0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
